// File: rtl/sha1_wb_master.sv
// Wishbone B4 classic master that loads one 512-bit block into the SHA1 slave,
// starts it, polls for completion and reads back the 160-bit digest.
module sha1_wb_master #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter logic [31:0] CTRL_OFS       = 32'h00,
  parameter logic [31:0] STATUS_OFS     = 32'h04,
  parameter logic [31:0] MSG_OFS        = 32'h10,
  parameter logic [31:0] DIGEST_OFS     = 32'h50,
  parameter logic [31:0] CTRL_START_VAL = 32'h1,
  parameter int          DONE_BIT       = 0,
  parameter int          TIMEOUT        = 255
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_n_i,
  input  logic         start_i,
  output logic         busy_o,
  input  logic         msg_valid_i,
  input  logic [31:0]  msg_data_i,
  output logic         msg_ready_o,
  output logic         digest_valid_o,
  output logic [159:0] digest_o,
  output logic         error_o,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic [31:0]  wbm_dat_i,
  input  logic         wbm_ack_i,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MSG_WAIT = 3'd1,
    MSG_WR   = 3'd2,
    CTRL_WR  = 3'd3,
    STAT_RD  = 3'd4,
    POLL_GAP = 3'd5,
    DIG_RD   = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [3:0]  idx;
  logic [2:0]  jdx;
  logic [7:0]  tcnt;
  logic [31:0] shadow [0:4];

  // Message stream: a word transfers on a rising edge where msg_valid_i && msg_ready_o.
  assign msg_ready_o = (state == MSG_WAIT);
  assign busy_o      = (state != IDLE);
  assign dbg_state   = state;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state          <= IDLE;
      idx            <= '0;
      jdx            <= '0;
      tcnt           <= '0;
      digest_valid_o <= 1'b0;
      digest_o       <= '0;
      error_o        <= 1'b0;
      wbm_cyc_o      <= 1'b0;
      wbm_stb_o      <= 1'b0;
      wbm_we_o       <= 1'b0;
      wbm_sel_o      <= '0;
      wbm_adr_o      <= '0;
      wbm_dat_o      <= '0;
      for (int k = 0; k < 5; k++) shadow[k] <= '0;
    end else begin
      digest_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state   <= MSG_WAIT;
            idx     <= '0;
            error_o <= 1'b0;
          end
        end
        MSG_WAIT: begin
          if (msg_valid_i) begin
            wbm_dat_o <= msg_data_i;
            wbm_adr_o <= BASE_ADDR + MSG_OFS + {26'd0, idx, 2'b00};
            state     <= MSG_WR;
          end
        end
        POLL_GAP: state <= STAT_RD;
        DONE: begin
          digest_o       <= {shadow[0], shadow[1], shadow[2], shadow[3], shadow[4]};
          digest_valid_o <= 1'b1;
          state          <= IDLE;
        end
        default: begin
          // Bus states: first cycle raises the strobe, then wait for ack or timeout.
          if (!wbm_stb_o) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_sel_o <= 4'hF;
            wbm_we_o  <= (state == MSG_WR) || (state == CTRL_WR);
            tcnt      <= '0;
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            case (state)
              MSG_WR: begin
                if (idx == 4'd15) begin
                  wbm_adr_o <= BASE_ADDR + CTRL_OFS;
                  wbm_dat_o <= CTRL_START_VAL;
                  state     <= CTRL_WR;
                end else begin
                  idx   <= idx + 4'd1;
                  state <= MSG_WAIT;
                end
              end
              CTRL_WR: begin
                wbm_adr_o <= BASE_ADDR + STATUS_OFS;
                wbm_dat_o <= '0;
                state     <= STAT_RD;
              end
              STAT_RD: begin
                if (wbm_dat_i[DONE_BIT]) begin
                  wbm_adr_o <= BASE_ADDR + DIGEST_OFS;
                  jdx       <= '0;
                  state     <= DIG_RD;
                end else begin
                  state <= POLL_GAP;
                end
              end
              DIG_RD: begin
                shadow[jdx] <= wbm_dat_i;
                if (jdx == 3'd4) begin
                  state <= DONE;
                end else begin
                  jdx       <= jdx + 3'd1;
                  wbm_adr_o <= wbm_adr_o + 32'd4;
                end
              end
              default: state <= IDLE;
            endcase
          end else if (tcnt == TMO_LAST) begin
            // Slave stopped answering: abandon the job, keep the old digest.
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            error_o   <= 1'b1;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_wb_master.sv
// Bench for sha1_wb_master: bus-functional SHA1 slave, message driver and
// scoreboards for bus transactions and digests.
module tb_sha1_wb_master;

  localparam logic [159:0] DIG_ABC = 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
  localparam logic [31:0]  A_CTRL  = 32'h3000_0000;
  localparam logic [31:0]  A_STAT  = 32'h3000_0004;
  localparam logic [31:0]  A_MSG   = 32'h3000_0010;
  localparam logic [31:0]  A_DIG   = 32'h3000_0050;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic         busy_o;
  logic         msg_valid_i;
  logic [31:0]  msg_data_i;
  logic         msg_ready_o;
  logic         digest_valid_o;
  logic [159:0] digest_o;
  logic         error_o;
  logic         wbm_cyc_o;
  logic         wbm_stb_o;
  logic         wbm_we_o;
  logic [3:0]   wbm_sel_o;
  logic [31:0]  wbm_adr_o;
  logic [31:0]  wbm_dat_o;
  logic [31:0]  wbm_dat_i;
  logic         wbm_ack_i;
  logic [2:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  // Expected bus transactions {we, adr, dat}; data compared only for writes.
  logic [64:0]  exp_q[$];
  logic [159:0] dig_q[$];
  logic [31:0]  msg_words [16];
  logic [31:0]  dig_words [5];

  int ack_delay     = 0;
  bit noack_ctrl    = 0;
  int polls_to_done = 3;
  int dv_pulses     = 0;
  int last_hi       = 0;

  sha1_wb_master dut (
    .wb_clk_i       (clk),
    .wb_rst_n_i     (rst_n),
    .start_i        (start_i),
    .busy_o         (busy_o),
    .msg_valid_i    (msg_valid_i),
    .msg_data_i     (msg_data_i),
    .msg_ready_o    (msg_ready_o),
    .digest_valid_o (digest_valid_o),
    .digest_o       (digest_o),
    .error_o        (error_o),
    .wbm_cyc_o      (wbm_cyc_o),
    .wbm_stb_o      (wbm_stb_o),
    .wbm_we_o       (wbm_we_o),
    .wbm_sel_o      (wbm_sel_o),
    .wbm_adr_o      (wbm_adr_o),
    .wbm_dat_o      (wbm_dat_o),
    .wbm_dat_i      (wbm_dat_i),
    .wbm_ack_i      (wbm_ack_i),
    .dbg_state      (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus-functional slave, acting on falling edges
  initial begin : slave
    bit          active;
    bit          cur_noack;
    logic [64:0] cur;
    logic [64:0] e;
    int          hi;
    int          wait_n;
    int          poll_cnt;
    logic [31:0] widx;
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    active    = 0;
    cur_noack = 0;
    poll_cnt  = 0;
    hi        = 0;
    wait_n    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wbm_ack_i = 1'b0;
        active    = 0;
      end else begin
        wbm_ack_i = 1'b0;
        if (active && !wbm_stb_o) begin
          active  = 0;
          last_hi = hi;
          checks++;
          if (hi !== (cur_noack ? 255 : ack_delay + 1)) begin
            errors++;
            $display("FAIL stb_len adr=%h: got %0d cycles, want %0d", cur[63:32], hi,
                     cur_noack ? 255 : ack_delay + 1);
          end
        end
        if (wbm_stb_o) begin
          if (!active) begin
            active    = 1;
            hi        = 1;
            wait_n    = ack_delay;
            cur       = {wbm_we_o, wbm_adr_o, wbm_dat_o};
            cur_noack = noack_ctrl && wbm_we_o && (wbm_adr_o == A_CTRL);
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_txn: got we=%b adr=%h dat=%h, want none", wbm_we_o,
                       wbm_adr_o, wbm_dat_o);
            end else begin
              e = exp_q.pop_front();
              if (wbm_we_o !== e[64] || wbm_adr_o !== e[63:32] ||
                  (e[64] && wbm_dat_o !== e[31:0]) || wbm_cyc_o !== 1'b1 || wbm_sel_o !== 4'hF) begin
                errors++;
                $display("FAIL txn: got we=%b adr=%h dat=%h cyc=%b sel=%h, want we=%b adr=%h dat=%h cyc=1 sel=f",
                         wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_cyc_o, wbm_sel_o, e[64], e[63:32], e[31:0]);
              end
            end
            if (wbm_we_o && wbm_adr_o == A_CTRL) poll_cnt = 0;
          end else begin
            hi++;
            checks++;
            if ({wbm_we_o, wbm_adr_o, wbm_dat_o} !== cur || wbm_cyc_o !== 1'b1 || wbm_sel_o !== 4'hF) begin
              errors++;
              $display("FAIL stable: got we=%b adr=%h dat=%h, want we=%b adr=%h dat=%h", wbm_we_o,
                       wbm_adr_o, wbm_dat_o, cur[64], cur[63:32], cur[31:0]);
            end
          end
          if (!cur_noack) begin
            if (wait_n == 0) begin
              wbm_ack_i = 1'b1;
              wbm_dat_i = '0;
              if (!wbm_we_o && wbm_adr_o == A_STAT) begin
                poll_cnt++;
                wbm_dat_i = (poll_cnt >= polls_to_done) ? 32'h1 : 32'h0;
              end else if (!wbm_we_o && wbm_adr_o >= A_DIG && wbm_adr_o < A_DIG + 32'd20) begin
                widx = (wbm_adr_o - A_DIG) >> 2;
                wbm_dat_i = dig_words[widx[2:0]];
              end
            end else begin
              wait_n--;
            end
          end
        end
      end
    end
  end

  // Digest scoreboard
  initial begin : digest_mon
    logic [159:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && digest_valid_o) begin
        dv_pulses++;
        checks++;
        if (dig_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_digest: got %h, want no pulse", digest_o);
        end else begin
          e = dig_q.pop_front();
          if (digest_o !== e) begin
            errors++;
            $display("FAIL digest: got %h, want %h", digest_o, e);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    bit ok;
    ok = 0;
    @(negedge clk);
    msg_valid_i = 1'b1;
    msg_data_i  = d;
    for (int n = 0; n < 300; n++) begin
      if (msg_ready_o) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL msg_ready_wait: got ready=0 for 300 cycles, want 1");
    end
    @(posedge clk);
    #1;
    msg_valid_i = 1'b0;
  endtask

  task automatic push_job_expect();
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, A_MSG + 32'(4 * i), msg_words[i]});
    exp_q.push_back({1'b1, A_CTRL, 32'h1});
    for (int i = 0; i < polls_to_done; i++) exp_q.push_back({1'b0, A_STAT, 32'h0});
    for (int j = 0; j < 5; j++) exp_q.push_back({1'b0, A_DIG + 32'(4 * j), 32'h0});
    dig_q.push_back(DIG_ABC);
  endtask

  task automatic run_job(input bit stall, input bit start_in_stat);
    int  p0;
    bit  ok;
    p0 = dv_pulses;
    push_job_expect();
    pulse_start();
    checks++;
    if (busy_o !== 1'b1 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL start_accept: got busy=%b error=%b, want busy=1 error=0", busy_o, error_o);
    end
    for (int i = 0; i < 16; i++) begin
      send_word(msg_words[i]);
      if (stall && i == 7) begin
        ok = 0;
        for (int n = 0; n < 300; n++) begin
          @(negedge clk);
          if (msg_ready_o) begin
            ok = 1;
            break;
          end
        end
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL stall_ready_wait: got ready=0, want 1");
        end
        for (int n = 0; n < 10; n++) begin
          @(negedge clk);
          checks++;
          if (msg_ready_o !== 1'b1 || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL stall: got ready=%b cyc=%b stb=%b, want ready=1 cyc=0 stb=0",
                     msg_ready_o, wbm_cyc_o, wbm_stb_o);
          end
        end
      end
    end
    if (start_in_stat) begin
      ok = 0;
      for (int n = 0; n < 500; n++) begin
        @(negedge clk);
        if (wbm_stb_o && !wbm_we_o && wbm_adr_o == A_STAT) begin
          ok = 1;
          break;
        end
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL stat_wait: got no status read, want one");
      end
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    ok = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (dv_pulses > p0) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL digest_wait: got no digest_valid in 2000 cycles, want one");
    end
    repeat (4) @(negedge clk);
    checks++;
    if (dv_pulses - p0 !== 1) begin
      errors++;
      $display("FAIL dv_count: got %0d pulses, want 1", dv_pulses - p0);
    end
    checks++;
    if (exp_q.size() !== 0 || busy_o !== 1'b0 || digest_o !== DIG_ABC) begin
      errors++;
      $display("FAIL job_end: got left=%0d busy=%b digest=%h, want left=0 busy=0 digest=%h",
               exp_q.size(), busy_o, digest_o, DIG_ABC);
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg_words[i] = 32'h0;
    msg_words[0]  = 32'h61626380;
    msg_words[15] = 32'h00000018;
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) msg_words[i] = $urandom_range(32'hFFFF_FFFF, 0);
  endtask

  // Test scenarios
  task automatic test_reset();
    rst_n       = 1'b0;
    start_i     = 1'b0;
    msg_valid_i = 1'b0;
    msg_data_i  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy_o, msg_ready_o, digest_valid_o, error_o} !== '0 ||
        wbm_adr_o !== '0 || wbm_dat_o !== '0 || digest_o !== '0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got cyc=%b stb=%b busy=%b ready=%b err=%b adr=%h digest=%h state=%0d, want all 0",
               wbm_cyc_o, wbm_stb_o, busy_o, msg_ready_o, error_o, wbm_adr_o, digest_o, dbg_state);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_abc();
    set_abc();
    run_job(0, 0);
  endtask

  task automatic test_msg_stall();
    set_random();
    run_job(1, 0);
  endtask

  task automatic test_ack_delay();
    set_random();
    ack_delay = 5;
    run_job(0, 0);
    ack_delay = 0;
  endtask

  task automatic test_start_while_busy();
    set_abc();
    run_job(0, 1);
  endtask

  task automatic test_timeout();
    int p0;
    bit ok;
    set_abc();
    p0 = dv_pulses;
    noack_ctrl = 1;
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, A_MSG + 32'(4 * i), msg_words[i]});
    exp_q.push_back({1'b1, A_CTRL, 32'h1});
    pulse_start();
    for (int i = 0; i < 16; i++) send_word(msg_words[i]);
    ok = 0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if (!busy_o) begin
        ok = 1;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (!ok || error_o !== 1'b1 || busy_o !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state: got ended=%b error=%b busy=%b cyc=%b, want 1 1 0 0",
               ok, error_o, busy_o, wbm_cyc_o);
    end
    checks++;
    if (last_hi !== 255 || digest_o !== DIG_ABC || dv_pulses !== p0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL timeout_result: got stb_cycles=%0d digest=%h pulses=%0d left=%0d, want 255 %h 0 0",
               last_hi, digest_o, dv_pulses - p0, exp_q.size(), DIG_ABC);
    end
    noack_ctrl = 0;
    // The next accepted start clears error_o; run_job checks it.
    run_job(0, 0);
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    set_random();
    ack_delay = 3;
    for (int i = 0; i < 10; i++) exp_q.push_back({1'b1, A_MSG + 32'(4 * i), msg_words[i]});
    pulse_start();
    for (int i = 0; i < 10; i++) send_word(msg_words[i]);
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (wbm_cyc_o && wbm_adr_o == A_MSG + 32'd36) begin
        ok = 1;
        break;
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy_o, msg_ready_o, digest_valid_o, error_o} !== '0 ||
        wbm_adr_o !== '0 || wbm_dat_o !== '0 || digest_o !== '0) begin
      errors++;
      $display("FAIL reset_mid_write: got seen=%b cyc=%b stb=%b busy=%b adr=%h dat=%h digest=%h, want seen=1 and all 0",
               ok, wbm_cyc_o, wbm_stb_o, busy_o, wbm_adr_o, wbm_dat_o, digest_o);
    end
    exp_q.delete();
    ack_delay = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    set_abc();
    run_job(0, 0);
  endtask

  initial begin
    dig_words[0] = DIG_ABC[159:128];
    dig_words[1] = DIG_ABC[127:96];
    dig_words[2] = DIG_ABC[95:64];
    dig_words[3] = DIG_ABC[63:32];
    dig_words[4] = DIG_ABC[31:0];
    test_reset();
    test_basic_abc();
    test_msg_stall();
    test_ack_delay();
    test_start_while_busy();
    test_timeout();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha1_wb_master.md
Name: sha1_wb_master

Overview:
- Wishbone B4 classic master that drives the SHA1 Wishbone slave from the initiator side.
- Accepts one 512-bit message block as a 16-word stream.
- Writes the block into the slave's message registers, writes the start command, and polls the status register until done.
- Reads back the 160-bit digest and presents it on a result port. Used as a standalone host for the SHA1 core in user-area integration and in test benches.

Parameters:
- BASE_ADDR, 32'h3000_0000, slave base address.
- CTRL_OFS, 32'h00, control register offset; writing CTRL_START_VAL starts hashing.
- STATUS_OFS, 32'h04, status register offset; bit DONE_BIT = digest ready.
- MSG_OFS, 32'h10, offset of message word 0; word i is at MSG_OFS+4*i, i=0..15.
- DIGEST_OFS, 32'h50, offset of digest word 0 (H0); word j is at DIGEST_OFS+4*j, j=0..4.
- CTRL_START_VAL, 32'h1, value written to CTRL.
- DONE_BIT, 0, bit index of done in STATUS.
- TIMEOUT, 255, maximum cycles to wait for wbm_ack_i per bus cycle (8-bit counter).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle job request; ignored while busy_o=1.
- busy_o  out  1  high from the cycle after an accepted start until return to IDLE.
- msg_valid_i  in  1  message word valid.
- msg_data_i  in  32  message word, word 0 first.
- msg_ready_o  out  1  block can accept a message word.
- digest_valid_o  out  1  one-cycle pulse when digest_o is updated.
- digest_o  out  160  H0 in [159:128] through H4 in [31:0]; held until the next digest.
- error_o  out  1  sticky ack-timeout flag; cleared on accepted start.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte selects; always 4'hF during a cycle, 0 otherwise.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  acknowledge.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-bus-cycle): all outputs 0, digest_o=0, FSM=IDLE, word counters=0.
- States and transitions:
  - IDLE: start_i -> MSG_WAIT, word index=0, error_o cleared.
  - MSG_WAIT: msg_ready_o=1. On msg_valid_i&&msg_ready_o, latch data, adr=BASE_ADDR+MSG_OFS+4*idx -> MSG_WR. msg_ready_o drops the next cycle, so at most one word is accepted per bus write.
  - MSG_WR: write cycle. On ack, if idx=15 -> CTRL_WR, else idx+1 -> MSG_WAIT.
  - CTRL_WR: write CTRL_START_VAL to BASE_ADDR+CTRL_OFS. On ack -> STAT_RD.
  - STAT_RD: read BASE_ADDR+STATUS_OFS. On ack:
    - if wbm_dat_i[DONE_BIT]=1 -> DIG_RD with j=0;
    - else -> POLL_GAP.
  - POLL_GAP: one idle cycle with cyc=stb=0, then -> STAT_RD.
  - DIG_RD: read BASE_ADDR+DIGEST_OFS+4*j and capture wbm_dat_i into a shadow register slot j. On ack with j=4 -> DONE, else j+1.
  - DONE: copy the shadow to digest_o, pulse digest_valid_o for 1 cycle -> IDLE.
- Bus rules:
  - cyc and stb are asserted together in the cycle after entering a bus state.
  - adr, dat, we and sel are stable while stb=1.
  - ack is sampled on the rising edge. cyc, stb and we deassert on the edge after ack is seen high, so no back-to-back stb without at least one idle cycle.
  - wbm_ack_i received while cyc=0 is ignored.
- Timeout: the counter is cleared at each stb assertion and increments while stb=1 and ack=0. Reaching TIMEOUT: drop cyc/stb, set error_o, -> IDLE, no digest_valid_o. The partially loaded message is discarded.
- busy_o=1 in every state except IDLE; start_i asserted while busy has no effect.
- digest_o holds its old value if a job ends in error.
- Address arithmetic is 32-bit, wrap-around ignored.

Test Plan:
- Bus-functional SHA1 slave model, message "abc" padded (word0=32'h61626380, words1-14=0, word15=32'h00000018), done after 3 polls -> 16 writes at 0x3000_0010..0x3000_004C, CTRL write of 0x1 to 0x3000_0000, 3 status reads with a 1-cycle gap between each, 5 digest reads; digest_o=160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D with a single digest_valid_o pulse.
- msg_valid_i stalled 10 cycles between words 7 and 8 -> no bus activity during the stall, msg_ready_o held high, written data unchanged and in order.
- Slave delays ack by 5 cycles on every access -> stb/adr/dat held stable for 5 cycles; the job completes with the correct digest.
- Slave never acks the CTRL write -> stb drops after exactly 255 stalled cycles, error_o=1, busy_o=0, digest_o unchanged; the next start clears error_o.
- start_i pulsed during STAT_RD -> ignored; exactly one digest_valid_o pulse.
- wb_rst_n_i asserted while cyc=1 in MSG_WR at word 9 -> cyc, stb and all outputs 0 in the same cycle. After release, a new job writes starting from word 0.
